// File: rtl/hopfield_recall_engine_if.sv
// Bus bundle for hopfield_recall_engine: weight loader, pattern load, recall control and status.
// The learn strobe exists only when HOPFIELD_HEBB_EN is defined.
interface hopfield_recall_engine_if #(
  parameter int N          = 25,
  parameter int WW         = 8,
  parameter int MAX_SWEEPS = 16
);
  localparam int AW = $clog2(N*N);
  localparam int SW = $clog2(MAX_SWEEPS+1);

  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [WW-1:0] wr_data;
  logic                 load_en;
  logic [N-1:0]         load_pattern;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 converged;
  logic [SW-1:0]        sweeps;
  logic [N-1:0]         state_out;
`ifdef HOPFIELD_HEBB_EN
  logic                 learn;
`endif

  modport master (
`ifdef HOPFIELD_HEBB_EN
    output learn,
`endif
    output wr_en, wr_addr, wr_data, load_en, load_pattern, start,
    input  busy, done, converged, sweeps, state_out
  );

  modport slave (
`ifdef HOPFIELD_HEBB_EN
    input  learn,
`endif
    input  wr_en, wr_addr, wr_data, load_en, load_pattern, start,
    output busy, done, converged, sweeps, state_out
  );
endinterface

// File: rtl/hopfield_recall_engine.sv
// Hopfield associative recall with a sequential MAC (one weight per clock), sync/async update,
// convergence detection and sweep limit. HOPFIELD_HEBB_EN adds on-chip Hebbian learning.
module hopfield_recall_engine #(
  parameter int N           = 25,
  parameter int WW          = 8,
  parameter int MAX_SWEEPS  = 16,
  parameter int UPDATE_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  hopfield_recall_engine_if.slave bus
);
  localparam int AW    = $clog2(N*N);
  localparam int ACC_W = WW + $clog2(N) + 1;
  localparam int SW    = $clog2(MAX_SWEEPS+1);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int NW    = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE, S_ACC, S_DECIDE, S_SWEEP_END, S_FIN
`ifdef HOPFIELD_HEBB_EN
    , S_LEARN
`endif
  } fsm_e;

  fsm_e fsm_q, fsm_d;

  logic signed [WW-1:0]    w_q [NW];
  logic signed [ACC_W-1:0] acc_q;
  logic [N-1:0]            s_q, shadow_q;
  logic [IW-1:0]           j_q, k_q;
  logic [AW-1:0]           addr_q;
  logic [SW-1:0]           sweeps_q;
  logic                    chg_q, conv_q;

  logic                    learn_go, start_go, j_last, k_last, new_k, busy, done;
  logic signed [WW-1:0]    w_rd;
  logic signed [ACC_W-1:0] w_ext, term;
  logic [SW-1:0]           sweeps_inc;

`ifdef HOPFIELD_HEBB_EN
  localparam logic signed [WW-1:0] WMAX = WW'((1 << (WW-1)) - 1);
  localparam logic signed [WW-1:0] WONE = WW'(1);
  logic [N-1:0]         pat_q;
  logic signed [WW-1:0] hebb_w;
  assign learn_go = bus.learn;
`else
  assign learn_go = 1'b0;
`endif

  assign start_go   = bus.start && !learn_go;
  assign j_last     = (j_q == IW'(N-1));
  assign k_last     = (k_q == IW'(N-1));
  assign w_rd       = w_q[addr_q];
  // Widen before negating so -(-2^(WW-1)) is representable.
  assign w_ext      = ACC_W'(w_rd);
  assign term       = s_q[j_q] ? w_ext : -w_ext;
  assign new_k      = (acc_q > 0);
  assign sweeps_inc = sweeps_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= S_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE: begin
`ifdef HOPFIELD_HEBB_EN
        if (bus.learn) fsm_d = S_LEARN; else
`endif
        if (bus.start) fsm_d = S_ACC;
      end
      S_ACC:       if (j_last) fsm_d = S_DECIDE;
      S_DECIDE:    fsm_d = k_last ? S_SWEEP_END : S_ACC;
      S_SWEEP_END: fsm_d = (!chg_q || sweeps_inc == SW'(MAX_SWEEPS)) ? S_FIN : S_ACC;
      S_FIN:       fsm_d = S_IDLE;
`ifdef HOPFIELD_HEBB_EN
      S_LEARN:     if (addr_q == AW'(N*N-1)) fsm_d = S_FIN;
`endif
      default:     fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (fsm_q)
      S_IDLE:  ;
      S_FIN:   done = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.converged = conv_q;
  assign bus.sweeps    = sweeps_q;
  assign bus.state_out = s_q;

`ifdef HOPFIELD_HEBB_EN
  always_comb begin
    hebb_w = w_rd;
    if (pat_q[k_q] == pat_q[j_q]) begin
      if (w_rd < WMAX)  hebb_w = w_rd + WONE;
    end else begin
      if (w_rd > -WMAX) hebb_w = w_rd - WONE;
    end
  end
`endif

  // Weight store is deliberately outside reset so an abort keeps the trained weights.
  always_ff @(posedge clk) begin
    if (fsm_q == S_IDLE && bus.wr_en) w_q[bus.wr_addr] <= bus.wr_data;
`ifdef HOPFIELD_HEBB_EN
    else if (fsm_q == S_LEARN && k_q != j_q) w_q[addr_q] <= hebb_w;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q      <= '0;
      shadow_q <= '0;
      acc_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      addr_q   <= '0;
      sweeps_q <= '0;
      chg_q    <= 1'b0;
      conv_q   <= 1'b0;
`ifdef HOPFIELD_HEBB_EN
      pat_q    <= '0;
`endif
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (bus.load_en) s_q <= bus.load_pattern;
`ifdef HOPFIELD_HEBB_EN
          if (bus.learn) pat_q <= bus.load_pattern;
`endif
          if (start_go || learn_go) begin
            acc_q  <= '0;
            j_q    <= '0;
            k_q    <= '0;
            addr_q <= '0;
            chg_q  <= 1'b0;
          end
          if (start_go) begin
            sweeps_q <= '0;
            conv_q   <= 1'b0;
          end
        end
        S_ACC: begin
          acc_q  <= acc_q + term;
          j_q    <= j_last ? '0 : j_q + 1'b1;
          addr_q <= addr_q + 1'b1;
        end
        S_DECIDE: begin
          acc_q <= '0;
          if (new_k != s_q[k_q]) chg_q <= 1'b1;
          // Async writes live state so later targets see it; sync stages into the shadow.
          if (UPDATE_MODE != 0) s_q[k_q]      <= new_k;
          else                  shadow_q[k_q] <= new_k;
          k_q <= k_q + 1'b1;
        end
        S_SWEEP_END: begin
          sweeps_q <= sweeps_inc;
          if (UPDATE_MODE == 0) s_q <= shadow_q;
          if (!chg_q) conv_q <= 1'b1;
          chg_q  <= 1'b0;
          j_q    <= '0;
          k_q    <= '0;
          addr_q <= '0;
        end
`ifdef HOPFIELD_HEBB_EN
        S_LEARN: begin
          addr_q <= addr_q + 1'b1;
          j_q    <= j_last ? '0 : j_q + 1'b1;
          if (j_last) k_q <= k_q + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hopfield_recall_engine.sv
// Bench for hopfield_recall_engine: N=25 sync instance driven from a vector table with a result
// scoreboard, plus two N=2 instances (sync and async) for oscillation, weight-edge and abort cases.
module tb_hopfield_recall_engine;
  localparam int NB      = 25;
  localparam int SWEEP_B = NB*(NB+1)+1;
  localparam int SWEEP_S = 2*3+1;
  localparam logic [NB-1:0] P    = 25'b0111010011100100001001110;
  localparam logic [NB-1:0] FLIP = 25'h0080081;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int bcnt   = 0;

  typedef struct packed { logic [NB-1:0] st; logic conv; int sw; } exp_t;
  typedef struct packed { logic wsel; logic [NB-1:0] pat; logic [NB-1:0] st; logic conv; int sw; } vec_t;
  exp_t sb[$];
  vec_t vt[6];

  hopfield_recall_engine_if #(.N(NB), .WW(8), .MAX_SWEEPS(16)) ba();
  hopfield_recall_engine_if #(.N(2),  .WW(8), .MAX_SWEEPS(16)) bs();
  hopfield_recall_engine_if #(.N(2),  .WW(8), .MAX_SWEEPS(16)) bq();

  hopfield_recall_engine #(.N(NB), .WW(8), .MAX_SWEEPS(16), .UPDATE_MODE(0)) u_big (.clk(clk), .rst(rst), .bus(ba));
  hopfield_recall_engine #(.N(2),  .WW(8), .MAX_SWEEPS(16), .UPDATE_MODE(0)) u_syn (.clk(clk), .rst(rst), .bus(bs));
  hopfield_recall_engine #(.N(2),  .WW(8), .MAX_SWEEPS(16), .UPDATE_MODE(1)) u_asy (.clk(clk), .rst(rst), .bus(bq));

  // Both N=2 instances see identical stimulus.
  logic       sm_wr_en, sm_load_en, sm_start;
  logic [1:0] sm_wr_addr, sm_pat;
  logic [7:0] sm_wr_data;
  assign bs.wr_en = sm_wr_en;     assign bq.wr_en = sm_wr_en;
  assign bs.wr_addr = sm_wr_addr; assign bq.wr_addr = sm_wr_addr;
  assign bs.wr_data = sm_wr_data; assign bq.wr_data = sm_wr_data;
  assign bs.load_en = sm_load_en; assign bq.load_en = sm_load_en;
  assign bs.load_pattern = sm_pat; assign bq.load_pattern = sm_pat;
  assign bs.start = sm_start;     assign bq.start = sm_start;
`ifdef HOPFIELD_HEBB_EN
  assign bs.learn = 1'b0;         assign bq.learn = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done on the big instance must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) bcnt = 0;
    else begin
      if (ba.busy) bcnt++;
      if (ba.done) begin
        chk("done_has_expectation", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("state_out", ba.state_out, e.st);
          chk("converged", ba.converged, e.conv);
          chk("sweeps", ba.sweeps, e.sw);
          chk("busy_cycles", bcnt, e.sw*SWEEP_B);
        end
        bcnt = 0;
      end
    end
  end

  task automatic wr_a(input int addr, input int val);
    ba.wr_en = 1'b1; ba.wr_addr = 10'(addr); ba.wr_data = 8'(val);
    @(posedge clk); #1 ba.wr_en = 1'b0;
  endtask

  task automatic load_w(input logic hebb);
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < NB; j++)
        wr_a(k*NB+j, (!hebb || k == j) ? 0 : ((P[k] == P[j]) ? 1 : -1));
  endtask

  task automatic start_a(input logic [NB-1:0] pat, input logic [NB-1:0] st, input logic conv, input int sw);
    sb.push_back('{st, conv, sw});
    ba.load_pattern = pat; ba.load_en = 1'b1; ba.start = 1'b1;
    @(posedge clk); #1 ba.load_en = 1'b0; ba.start = 1'b0;
  endtask

  task automatic wait_a(input int limit);
    bit seen = 0;
    for (int n = 0; n < limit && !seen; n++) begin
      @(negedge clk);
      seen = ba.done;
    end
    chk("done_within_bound", seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic wr_s(input int addr, input int val);
    sm_wr_en = 1'b1; sm_wr_addr = 2'(addr); sm_wr_data = 8'(val);
    @(posedge clk); #1 sm_wr_en = 1'b0;
  endtask

  task automatic start_s(input logic [1:0] pat);
    sm_pat = pat; sm_load_en = 1'b1; sm_start = 1'b1;
    @(posedge clk); #1 sm_load_en = 1'b0; sm_start = 1'b0;
  endtask

  task automatic wait_s(input string nm, input logic [1:0] es, input logic cs, input int ss,
                        input logic [1:0] ea, input logic ca, input int sa);
    bit ds = 0, da = 0;
    int ns = 0, na = 0, sw_s = 0, sw_a = 0;
    logic [1:0] st_s = 'x, st_a = 'x;
    logic cv_s = 1'bx, cv_a = 1'bx;
    for (int n = 0; n < 400 && !(ds && da); n++) begin
      @(negedge clk);
      if (!ds) begin
        if (bs.busy) ns++;
        if (bs.done) begin ds = 1; st_s = bs.state_out; cv_s = bs.converged; sw_s = int'(bs.sweeps); end
      end
      if (!da) begin
        if (bq.busy) na++;
        if (bq.done) begin da = 1; st_a = bq.state_out; cv_a = bq.converged; sw_a = int'(bq.sweeps); end
      end
    end
    chk({nm, "_sync_done"}, ds, 1);
    chk({nm, "_sync_state"}, st_s, es);
    chk({nm, "_sync_conv"}, cv_s, cs);
    chk({nm, "_sync_sweeps"}, sw_s, ss);
    chk({nm, "_sync_busy"}, ns, ss*SWEEP_S);
    chk({nm, "_async_done"}, da, 1);
    chk({nm, "_async_state"}, st_a, ea);
    chk({nm, "_async_conv"}, cv_a, ca);
    chk({nm, "_async_sweeps"}, sw_a, sa);
    chk({nm, "_async_busy"}, na, sa*SWEEP_S);
    @(posedge clk); #1;
  endtask

  initial begin
    int loaded = -1;
    int nd = 0;
    rst = 1'b1;
    ba.wr_en = 0; ba.wr_addr = '0; ba.wr_data = '0; ba.load_en = 0; ba.load_pattern = '0; ba.start = 0;
`ifdef HOPFIELD_HEBB_EN
    ba.learn = 1'b0;
`endif
    sm_wr_en = 0; sm_wr_addr = '0; sm_wr_data = '0; sm_load_en = 0; sm_pat = '0; sm_start = 0;

    vt[0] = '{1'b0, 25'h1555555, 25'h0,  1'b1, 2};
    vt[1] = '{1'b0, 25'h0,       25'h0,  1'b1, 1};
    vt[2] = '{1'b1, P ^ FLIP,    P,      1'b1, 2};
    vt[3] = '{1'b1, P,           P,      1'b1, 1};
    vt[4] = '{1'b1, ~P,          ~P,     1'b1, 1};
    vt[5] = '{1'b1, 25'h0,       P,      1'b1, 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state_out", ba.state_out, 0);
    chk("rst_busy", ba.busy, 0);
    chk("rst_done", ba.done, 0);
    chk("rst_converged", ba.converged, 0);
    chk("rst_sweeps", ba.sweeps, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // N=2 oscillator; the last weight write, load and start share one cycle.
    wr_s(0, 0); wr_s(1, -1); wr_s(2, 5); wr_s(3, 0);
    sm_wr_en = 1'b1; sm_wr_addr = 2'd2; sm_wr_data = 8'hFF;
    sm_pat = 2'b00; sm_load_en = 1'b1; sm_start = 1'b1;
    @(posedge clk); #1 sm_wr_en = 0; sm_load_en = 0; sm_start = 0;
    wait_s("osc", 2'b00, 1'b0, 16, 2'b01, 1'b1, 2);

    // Most-negative weight must negate exactly to +128.
    wr_s(1, -128); wr_s(2, 0);
    start_s(2'b00);
    wait_s("wmin", 2'b01, 1'b1, 2, 2'b01, 1'b1, 2);

    // Diagonal weight participates.
    wr_s(3, 3);
    start_s(2'b10);
    wait_s("diag", 2'b10, 1'b1, 1, 2'b10, 1'b1, 1);

    for (int i = 0; i < 6; i++) begin
      if (int'(vt[i].wsel) != loaded) begin
        load_w(vt[i].wsel);
        loaded = int'(vt[i].wsel);
      end
      start_a(vt[i].pat, vt[i].st, vt[i].conv, vt[i].sw);
      wait_a(3000);
    end

    // Write, load and start while busy must all be dropped.
    start_a(P, P, 1'b1, 1);
    repeat (20) @(posedge clk);
    #1 ba.wr_en = 1'b1; ba.wr_addr = 10'd1; ba.wr_data = 8'sd100;
    ba.load_en = 1'b1; ba.load_pattern = ~P; ba.start = 1'b1;
    @(posedge clk); #1 ba.wr_en = 0; ba.load_en = 0; ba.start = 0;
    wait_a(3000);
    start_a(P, P, 1'b1, 1);
    wait_a(3000);

    // Abort mid-ACC: outputs clear at once, no done, weights survive.
    start_a(P ^ FLIP, P, 1'b1, 2);
    repeat (300) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", ba.busy, 0);
    chk("abort_done", ba.done, 0);
    chk("abort_state_out", ba.state_out, 0);
    chk("abort_converged", ba.converged, 0);
    chk("abort_sweeps", ba.sweeps, 0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    for (int n = 0; n < 1400; n++) begin
      @(negedge clk);
      if (ba.done) nd++;
    end
    chk("abort_no_done", nd, 0);
    @(posedge clk); #1;
    start_a(P ^ FLIP, P, 1'b1, 2);
    wait_a(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
